// File: rtl/snitch_icache_event_counters.sv
// Sums per-port L0 instruction-cache events into four saturating counters with
// atomic snapshot shadows, snapshot-and-clear, and a one-cycle read port.
module snitch_icache_event_counters #(
    parameter int unsigned NR_FETCH_PORTS = 1,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [4*NR_FETCH_PORTS-1:0]   events_i,
    input  logic                          clear_i,
    input  logic                          snapshot_i,
    input  logic                          rd_req_i,
    input  logic [1:0]                    rd_addr_i,
    output logic                          rd_rsp_valid_o,
    output logic [CNT_WIDTH-1:0]          rd_rsp_data_o,
    output logic [3:0]                    overflow_o
);

    localparam int unsigned INC_W = $clog2(NR_FETCH_PORTS + 1);

    // Index k: 0 miss, 1 hit, 2 prefetch, 3 double_hit (event bit 3-k).
    logic [CNT_WIDTH-1:0] cnt_q    [4];
    logic [CNT_WIDTH-1:0] shadow_q [4];
    logic [INC_W-1:0]     inc      [4];
    logic [CNT_WIDTH:0]   sum      [4];

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            inc[k] = '0;
            for (int p = 0; p < NR_FETCH_PORTS; p++) begin
                inc[k] = inc[k] + INC_W'(events_i[4*p + 3 - k]);
            end
            // One extra bit catches the carry out that signals saturation.
            sum[k] = {1'b0, cnt_q[k]} + (CNT_WIDTH + 1)'(inc[k]);
        end
    end

    // NOTE: non-blocking assignments let the snapshot and the read port sample
    // the pre-edge counter and shadow values even though they update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the shadow arrays are plain flops, not RAM, so resetting
            // them is cheap and the read port never returns stale data.
            for (int k = 0; k < 4; k++) begin
                cnt_q[k]    <= '0;
                shadow_q[k] <= '0;
            end
            overflow_o     <= '0;
            rd_rsp_valid_o <= 1'b0;
            rd_rsp_data_o  <= '0;
        end else begin
            if (snapshot_i) begin
                for (int k = 0; k < 4; k++) begin
                    shadow_q[k] <= cnt_q[k];
                end
            end

            if (clear_i) begin
                for (int k = 0; k < 4; k++) begin
                    cnt_q[k] <= '0;
                end
                overflow_o <= '0;
            end else if (enable_i) begin
                for (int k = 0; k < 4; k++) begin
                    if (sum[k][CNT_WIDTH]) begin
                        cnt_q[k]      <= '1;
                        overflow_o[k] <= 1'b1;
                    end else begin
                        cnt_q[k] <= sum[k][CNT_WIDTH-1:0];
                    end
                end
            end

            rd_rsp_valid_o <= rd_req_i;
            if (rd_req_i) begin
                rd_rsp_data_o <= shadow_q[rd_addr_i];
            end
        end
    end

endmodule
